rs_encoder: RTL



---
 rtl/rs_pkg.sv | 37 +++
 rtl/gf8_mul.sv | 40 ++++
 rtl/rs_encoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pkg
//  Description : Shared constants and types for the RS(7,3) codec over GF(8).
//                Field is GF(2^3) with primitive polynomial x^3+x+1, polynomial
//                basis, alpha = 3'b010. Generator polynomial
//                g(x) = x^4 + a^3 x^3 + x^2 + a x + a^3 (roots a^1..a^4).
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

    localparam int RS_M    = 3;             // bits per symbol
    localparam int RS_N    = 7;             // codeword length in symbols
    localparam int RS_K    = 3;             // message length in symbols
    localparam int RS_NPAR = RS_N - RS_K;   // parity symbols

    localparam int MSG_W   = RS_K * RS_M;   // packed message width
    localparam int CW_W    = RS_N * RS_M;   // packed codeword width

    localparam logic [RS_M:0] PRIM_POLY = 4'b1011;

    typedef logic [RS_M-1:0] gf_sym_t;

    // Generator coefficients, lowest degree first.
    localparam gf_sym_t G0 = 3'b011;
    localparam gf_sym_t G1 = 3'b010;
    localparam gf_sym_t G2 = 3'b001;
    localparam gf_sym_t G3 = 3'b011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        DONE   = 2'd2
    } enc_state_t;

endpackage : rs_pkg
`default_nettype wire

// File: rtl/gf8_mul.sv
`default_nettype none
// ============================================================================
//  Module      : gf8_mul
//  Description : Combinational GF(2^3) multiplier, polynomial basis, reduced
//                modulo PRIM_POLY.
//  Ports       : a, b  - operands
//                p     - product a*b in GF(8)
//  Revision    : 1.0 - initial release
// ============================================================================
module gf8_mul
    import rs_pkg::*;
(
    input  logic [RS_M-1:0] a,
    input  logic [RS_M-1:0] b,
    output logic [RS_M-1:0] p
);

    // Carry-less product has degree up to 2*(RS_M-1).
    logic [2*RS_M-2:0] w_prod;

    always_comb begin
        w_prod = '0;
        for (int i = 0; i < RS_M; i++) begin
            if (b[i]) begin
                w_prod = w_prod ^ ({{(RS_M-1){1'b0}}, a} << i);
            end
        end
        // Fold the high-order terms back in, top bit first, so each
        // reduction step can only affect lower bits still to be examined.
        for (int i = 2*RS_M-2; i >= RS_M; i--) begin
            if (w_prod[i]) begin
                w_prod = w_prod ^ ({{(RS_M-2){1'b0}}, PRIM_POLY} << (i - RS_M));
            end
        end
    end

    assign p = w_prod[RS_M-1:0];

endmodule : gf8_mul
`default_nettype wire

// File: rtl/rs_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : rs_encoder
//  Description : Systematic RS(7,3) encoder over GF(8). Accepts a 3-symbol
//                message, runs a symbol-serial parity LFSR for 3 cycles and
//                presents the 7-symbol codeword {msg, p3, p2, p1, p0}.
//  Ports       : clk        - rising-edge clock
//                reset      - asynchronous active-low reset
//                enable     - 0 freezes all state and blocks handshakes
//                msg_data   - message, [8:6] is the first symbol
//                msg_valid  - message offered
//                msg_ready  - encoder accepts a message this cycle
//                cw_data    - codeword, [20:18] is the first symbol
//                cw_valid   - codeword valid, held until accepted
//                cw_ready   - downstream accepts the codeword
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_encoder
    import rs_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [MSG_W-1:0] msg_data,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic [CW_W-1:0]  cw_data,
    output logic             cw_valid,
    input  logic             cw_ready
);

    enc_state_t       r_state;
    logic [MSG_W-1:0] r_msg;
    gf_sym_t          r_p0, r_p1, r_p2, r_p3;
    logic [1:0]       r_cnt;
    logic [CW_W-1:0]  r_cw_data;
    logic             r_cw_valid;

    gf_sym_t w_sym, w_fb;
    gf_sym_t w_fb_g0, w_fb_g1, w_fb_g2, w_fb_g3;
    gf_sym_t w_p0_nxt, w_p1_nxt, w_p2_nxt, w_p3_nxt;
    logic    w_msg_hs;

    // Gating with reset keeps msg_ready low for the whole reset window.
    assign msg_ready = reset & enable &
                       ((r_state == IDLE) | ((r_state == DONE) & cw_ready));
    assign w_msg_hs  = msg_ready & msg_valid;

    // Highest-degree symbol is fed first.
    always_comb begin
        case (r_cnt)
            2'd0:    w_sym = r_msg[2*RS_M +: RS_M];
            2'd1:    w_sym = r_msg[1*RS_M +: RS_M];
            default: w_sym = r_msg[0*RS_M +: RS_M];
        endcase
    end

    assign w_fb = w_sym ^ r_p3;

    gf8_mul u_mul_g0 (.a(w_fb), .b(G0), .p(w_fb_g0));
    gf8_mul u_mul_g1 (.a(w_fb), .b(G1), .p(w_fb_g1));
    gf8_mul u_mul_g2 (.a(w_fb), .b(G2), .p(w_fb_g2));
    gf8_mul u_mul_g3 (.a(w_fb), .b(G3), .p(w_fb_g3));

    assign w_p3_nxt = r_p2 ^ w_fb_g3;
    assign w_p2_nxt = r_p1 ^ w_fb_g2;
    assign w_p1_nxt = r_p0 ^ w_fb_g1;
    assign w_p0_nxt = w_fb_g0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_msg      <= '0;
            r_p0       <= '0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_p3       <= '0;
            r_cnt      <= '0;
            r_cw_data  <= '0;
            r_cw_valid <= 1'b0;
        end else if (enable) begin
            case (r_state)
                IDLE: begin
                    if (w_msg_hs) begin
                        r_msg   <= msg_data;
                        r_p0    <= '0;
                        r_p1    <= '0;
                        r_p2    <= '0;
                        r_p3    <= '0;
                        r_cnt   <= '0;
                        r_state <= ENCODE;
                    end
                end
                ENCODE: begin
                    r_p0  <= w_p0_nxt;
                    r_p1  <= w_p1_nxt;
                    r_p2  <= w_p2_nxt;
                    r_p3  <= w_p3_nxt;
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd2) begin
                        // Codeword uses the parity produced by this last step.
                        r_cw_data  <= {r_msg, w_p3_nxt, w_p2_nxt, w_p1_nxt, w_p0_nxt};
                        r_cw_valid <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (cw_ready) begin
                        r_cw_valid <= 1'b0;
                        if (w_msg_hs) begin
                            r_msg   <= msg_data;
                            r_p0    <= '0;
                            r_p1    <= '0;
                            r_p2    <= '0;
                            r_p3    <= '0;
                            r_cnt   <= '0;
                            r_state <= ENCODE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cw_data  = r_cw_data;
    assign cw_valid = r_cw_valid;

endmodule : rs_encoder
`default_nettype wire
